// File: rtl/b16_muldiv_if.sv
// Request/result bundle between the b16 core and the iterative multiply/divide unit.
interface b16_muldiv_if #(
    parameter int l = 16
);
    logic         start;
    logic         op;
    logic [l-1:0] a;
    logic [l-1:0] b;
    logic         busy;
    logic         done;
    logic [l-1:0] hi;
    logic [l-1:0] lo;
    logic         dz;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, dz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, dz
    );
endinterface

// File: rtl/b16_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per clock.
// The accumulator pair doubles as the result registers, so hi/lo hold until the next run.
module b16_muldiv #(
    parameter int l = 16
) (
    input logic          clk,
    input logic          nreset,
    b16_muldiv_if.slave  bus
);
    localparam int cw = $clog2(l);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [cw-1:0] cnt;
    logic         mode;
    logic [l-1:0] opnd;
    logic [l-1:0] acc_hi;
    logic [l-1:0] acc_lo;
    logic         dz_pend;
    logic         dz;
    logic         load;
    logic         step;
    logic         last;

    logic [l-1:0] addend;
    logic [l:0]   mul_sum;
    logic [l:0]   div_shift;
    logic [l:0]   div_trial;
    logic [l-1:0] step_hi;
    logic [l-1:0] step_lo;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    last      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply shifts the product right through {carry, acc_hi, acc_lo}; divide shifts the
    // dividend out of acc_lo's MSB into the remainder while quotient bits fill its LSB.
    always_comb begin
        addend    = acc_lo[0] ? opnd : {l{1'b0}};
        mul_sum   = {1'b0, acc_hi} + {1'b0, addend};
        div_shift = {acc_hi, acc_lo[l-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (mode) begin
            if (!div_trial[l]) begin
                step_hi = div_trial[l-1:0];
                step_lo = {acc_lo[l-2:0], 1'b1};
            end else begin
                step_hi = div_shift[l-1:0];
                step_lo = {acc_lo[l-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[l:1];
            step_lo = {mul_sum[0], acc_lo[l-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt     <= '0;
            mode    <= 1'b0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            dz_pend <= 1'b0;
            dz      <= 1'b0;
        end else if (load) begin
            cnt     <= cw'(l - 1);
            mode    <= bus.op;
            opnd    <= bus.op ? bus.b : bus.a;
            acc_hi  <= '0;
            acc_lo  <= bus.op ? bus.a : bus.b;
            dz_pend <= bus.op && (bus.b == '0);
        end else if (step) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last) begin
                dz <= dz_pend;
            end else begin
                cnt <= cnt - cw'(1);
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.hi   = acc_hi;
    assign bus.lo   = acc_lo;
    assign bus.dz   = dz;
endmodule
